mask_matcher_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-bit combinational mask matcher. It takes a weight bitmask and an activation bitmask per beat. For each operand it produces a packed match bitmask, plus operand counts and the matched-pair count. It adds valid/ready flow control, a fixed two-stage pipeline, and a per-group running match total delimited by a last flag. It sits between the sparse-operand fetch logic and the PE operand selector.

---
 rtl/mask_matcher_pipe_pkg.sv | 26 ++
 rtl/mask_matcher_pipe_if.sv | 35 +++
 rtl/mask_matcher_pipe_prefix_count.sv | 21 ++
 rtl/mask_matcher_pipe.sv | 152 +++++++++++++++
 tb/tb_mask_matcher_pipe.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mask_matcher_pipe_pkg.sv
// Shared helpers for the pipelined mask matcher: count/accumulator widths and
// a population count usable on any mask up to the widest supported width.
package mask_match_pkg;

    localparam int MAX_MASK_WIDTH = 64;

    function automatic int calc_cw(input int width);
        return $clog2(width + 1);
    endfunction

    // One bit wider than both operands so an accumulate never wraps before
    // the saturation compare sees it.
    function automatic int calc_sum_width(input int acc_width, input int cw);
        return ((acc_width > cw) ? acc_width : cw) + 1;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_MASK_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_MASK_WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mask_matcher_pipe_if.sv
// Valid/ready stream bundle carrying mask pairs in and match results out.
interface mask_matcher_pipe_if #(
    parameter int MASK_WIDTH = 16,
    parameter int ACC_WIDTH  = 16
) ();
    localparam int CW = mask_match_pkg::calc_cw(MASK_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [MASK_WIDTH-1:0] in_bitmask_w;
    logic [MASK_WIDTH-1:0] in_bitmask_a;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [MASK_WIDTH-1:0] out_packed_w;
    logic [MASK_WIDTH-1:0] out_packed_a;
    logic [CW-1:0]         out_num_w;
    logic [CW-1:0]         out_num_a;
    logic [CW-1:0]         out_num_match;
    logic                  out_last;
    logic [ACC_WIDTH-1:0]  out_group_total;

    modport slave (
        input  in_valid, in_bitmask_w, in_bitmask_a, in_last, out_ready,
        output in_ready, out_valid, out_packed_w, out_packed_a,
               out_num_w, out_num_a, out_num_match, out_last, out_group_total
    );

    modport master (
        output in_valid, in_bitmask_w, in_bitmask_a, in_last, out_ready,
        input  in_ready, out_valid, out_packed_w, out_packed_a,
               out_num_w, out_num_a, out_num_match, out_last, out_group_total
    );

endinterface

// File: rtl/mask_matcher_pipe_prefix_count.sv
// Combinational LSB-first exclusive prefix popcount: prefix[i] counts the set
// bits of mask strictly below position i; total is the full popcount.
module mask_prefix_count
    import mask_match_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CW = calc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [WIDTH-1:0][CW-1:0] prefix,
    output logic [CW-1:0]            total
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
        localparam logic [WIDTH-1:0] BELOW = (WIDTH'(1) << gi) - WIDTH'(1);
        assign prefix[gi] = CW'(popcount(MAX_MASK_WIDTH'(mask & BELOW)));
    end

    assign total = CW'(popcount(MAX_MASK_WIDTH'(mask)));

endmodule

// File: rtl/mask_matcher_pipe.sv
// Two-stage valid/ready mask matcher: S1 computes match and prefix counts,
// S2 scatter-compresses into packed match masks and keeps a group total.
module mask_matcher_pipe
    import mask_match_pkg::*;
#(
    parameter int MASK_WIDTH = 16,
    parameter int ACC_WIDTH  = 16
) (
    input logic                clock,
    input logic                reset,
    mask_matcher_pipe_if.slave bus
);

    localparam int CW = calc_cw(MASK_WIDTH);
    localparam int SW = calc_sum_width(ACC_WIDTH, CW);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    logic s1_en;
    logic s2_en;

    logic [MASK_WIDTH-1:0]         match_next;
    logic [MASK_WIDTH-1:0][CW-1:0] pref_w_next;
    logic [MASK_WIDTH-1:0][CW-1:0] pref_a_next;
    logic [CW-1:0]                 num_w_next;
    logic [CW-1:0]                 num_a_next;
    logic [CW-1:0]                 num_match_next;

    logic                          s1_valid_reg;
    logic                          s1_last_reg;
    logic [MASK_WIDTH-1:0]         s1_match_reg;
    logic [MASK_WIDTH-1:0][CW-1:0] s1_pref_w_reg;
    logic [MASK_WIDTH-1:0][CW-1:0] s1_pref_a_reg;
    logic [CW-1:0]                 s1_num_w_reg;
    logic [CW-1:0]                 s1_num_a_reg;
    logic [CW-1:0]                 s1_num_match_reg;

    logic [MASK_WIDTH-1:0] packed_w_next;
    logic [MASK_WIDTH-1:0] packed_a_next;
    logic [SW-1:0]         sum_next;
    logic [ACC_WIDTH-1:0]  total_next;

    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic [MASK_WIDTH-1:0] packed_w_reg;
    logic [MASK_WIDTH-1:0] packed_a_reg;
    logic [CW-1:0]         num_w_reg;
    logic [CW-1:0]         num_a_reg;
    logic [CW-1:0]         num_match_reg;
    logic [ACC_WIDTH-1:0]  total_reg;
    logic [ACC_WIDTH-1:0]  acc_reg;

    // Each stage advances when its successor has room or is draining.
    assign s2_en = !out_valid_reg || bus.out_ready;
    assign s1_en = !s1_valid_reg || s2_en;

    assign match_next     = bus.in_bitmask_w & bus.in_bitmask_a;
    assign num_match_next = CW'(popcount(MAX_MASK_WIDTH'(match_next)));

    mask_prefix_count #(.WIDTH(MASK_WIDTH)) u_prefix_w (
        .mask   (bus.in_bitmask_w),
        .prefix (pref_w_next),
        .total  (num_w_next)
    );

    mask_prefix_count #(.WIDTH(MASK_WIDTH)) u_prefix_a (
        .mask   (bus.in_bitmask_a),
        .prefix (pref_a_next),
        .total  (num_a_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg     <= 1'b0;
            s1_last_reg      <= 1'b0;
            s1_match_reg     <= '0;
            s1_pref_w_reg    <= '0;
            s1_pref_a_reg    <= '0;
            s1_num_w_reg     <= '0;
            s1_num_a_reg     <= '0;
            s1_num_match_reg <= '0;
        end else if (s1_en) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_last_reg      <= bus.in_last;
                s1_match_reg     <= match_next;
                s1_pref_w_reg    <= pref_w_next;
                s1_pref_a_reg    <= pref_a_next;
                s1_num_w_reg     <= num_w_next;
                s1_num_a_reg     <= num_a_next;
                s1_num_match_reg <= num_match_next;
            end
        end
    end

    // Output bit k collects every matched position whose rank among the
    // operand's set bits is k; ranks are unique, so at most one hit per bit.
    for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_scatter
        logic [MASK_WIDTH-1:0] hit_w;
        logic [MASK_WIDTH-1:0] hit_a;
        always_comb begin
            hit_w = '0;
            hit_a = '0;
            for (int i = 0; i < MASK_WIDTH; i++) begin
                hit_w[i] = s1_match_reg[i] && (s1_pref_w_reg[i] == CW'(gi));
                hit_a[i] = s1_match_reg[i] && (s1_pref_a_reg[i] == CW'(gi));
            end
        end
        assign packed_w_next[gi] = |hit_w;
        assign packed_a_next[gi] = |hit_a;
    end

    assign sum_next   = SW'(acc_reg) + SW'(s1_num_match_reg);
    assign total_next = (sum_next > SW'(ACC_MAX)) ? ACC_MAX : ACC_WIDTH'(sum_next);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            packed_w_reg  <= '0;
            packed_a_reg  <= '0;
            num_w_reg     <= '0;
            num_a_reg     <= '0;
            num_match_reg <= '0;
            total_reg     <= '0;
            acc_reg       <= '0;
        end else if (s2_en) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_last_reg  <= s1_last_reg;
                packed_w_reg  <= packed_w_next;
                packed_a_reg  <= packed_a_next;
                num_w_reg     <= s1_num_w_reg;
                num_a_reg     <= s1_num_a_reg;
                num_match_reg <= s1_num_match_reg;
                total_reg     <= total_next;
                // A closing beat still reports its inclusive total above.
                acc_reg       <= s1_last_reg ? '0 : total_next;
            end
        end
    end

    assign bus.in_ready        = s1_en;
    assign bus.out_valid       = out_valid_reg;
    assign bus.out_packed_w    = packed_w_reg;
    assign bus.out_packed_a    = packed_a_reg;
    assign bus.out_num_w       = num_w_reg;
    assign bus.out_num_a       = num_a_reg;
    assign bus.out_num_match   = num_match_reg;
    assign bus.out_last        = out_last_reg;
    assign bus.out_group_total = total_reg;

endmodule

// File: tb/tb_mask_matcher_pipe.sv
// Bench for mask_matcher_pipe: directed vector table, random streaming against
// a rank-based reference model, reset mid-flight, and 64-bit saturation.
module tb_mask_matcher_pipe;

    typedef struct {
        logic [15:0] w;
        logic [15:0] a;
        logic        last;
        logic [15:0] pw;
        logic [15:0] pa;
        int          nw;
        int          na;
        int          nm;
        int          tot;
    } vec_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] a;
        logic        last;
        logic [15:0] pw;
        logic [15:0] pa;
        int          nw;
        int          na;
        int          nm;
        int          tot;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   acc_m = 0;

    always #5 clock = ~clock;

    mask_matcher_pipe_if #(.MASK_WIDTH(16), .ACC_WIDTH(16)) b16 ();
    mask_matcher_pipe_if #(.MASK_WIDTH(64), .ACC_WIDTH(8))  b64 ();

    mask_matcher_pipe #(.MASK_WIDTH(16), .ACC_WIDTH(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (b16)
    );

    mask_matcher_pipe #(.MASK_WIDTH(64), .ACC_WIDTH(8)) dut64 (
        .clock (clock),
        .reset (reset),
        .bus   (b64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rank-based model: the k-th set bit of one operand maps to packed bit k,
    // set when the other operand has a bit at the same position.
    function automatic void ref_model(input logic [63:0] w, input logic [63:0] a, input int width,
                                      output logic [63:0] pw, output logic [63:0] pa,
                                      output int nw, output int na, output int nm);
        pw = '0; pa = '0; nw = 0; na = 0; nm = 0;
        for (int p = 0; p < width; p++) begin
            if (w[p]) begin pw[nw] = a[p]; nw++; end
            if (a[p]) begin pa[na] = w[p]; na++; end
            if (w[p] && a[p]) nm++;
        end
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        acc_m = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clock);
        b16.out_ready = 1'b1;
        b16.in_valid = 1'b1;
        b16.in_bitmask_w = v.w;
        b16.in_bitmask_a = v.a;
        b16.in_last = v.last;
        #1 check({tag, ".in_ready"}, 64'(b16.in_ready), 64'd1);
        @(negedge clock);
        b16.in_valid = 1'b0;
        check({tag, ".lat1_valid"}, 64'(b16.out_valid), 64'd0);
        @(negedge clock);
        check({tag, ".lat2_valid"}, 64'(b16.out_valid), 64'd1);
        check({tag, ".packed_w"}, 64'(b16.out_packed_w), 64'(v.pw));
        check({tag, ".packed_a"}, 64'(b16.out_packed_a), 64'(v.pa));
        check({tag, ".num_w"}, 64'(b16.out_num_w), 64'(v.nw));
        check({tag, ".num_a"}, 64'(b16.out_num_a), 64'(v.na));
        check({tag, ".num_match"}, 64'(b16.out_num_match), 64'(v.nm));
        check({tag, ".last"}, 64'(b16.out_last), 64'(v.last));
        check({tag, ".total"}, 64'(b16.out_group_total), 64'(v.tot));
        $display("txn %s w=%h a=%h pw=%h pa=%h total=%0d", tag, v.w, v.a,
                 b16.out_packed_w, b16.out_packed_a, b16.out_group_total);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        exp_t q[$];
        exp_t e;
        vec_t v;

        tbl[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16, 0, 0, 0};
        tbl[1] = '{16'hF00F, 16'hFFFF, 1'b1, 16'h00FF, 16'hF00F, 8, 16, 8, 8};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16, 16, 16, 16};
        tbl[3] = '{16'hF00F, 16'hFFFF, 1'b0, 16'h00FF, 16'hF00F, 8, 16, 8, 24};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 0, 0, 0, 24};
        tbl[5] = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1, 1, 1, 1};
        tbl[6] = '{16'h00F0, 16'h0F30, 1'b1, 16'h0003, 16'h0003, 4, 6, 2, 2};
        tbl[7] = '{16'hAAAA, 16'hFF00, 1'b1, 16'h00F0, 16'h00AA, 8, 8, 4, 4};

        b16.in_valid = 1'b0; b16.in_bitmask_w = '0; b16.in_bitmask_a = '0;
        b16.in_last = 1'b0; b16.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_bitmask_w = '0; b64.in_bitmask_a = '0;
        b64.in_last = 1'b0; b64.out_ready = 1'b1;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset.out_valid", 64'(b16.out_valid), 64'd0);
        check("reset.in_ready", 64'(b16.in_ready), 64'd1);
        check("reset.data", {b16.out_packed_w, b16.out_packed_a, 1'b0, b16.out_num_w,
                             b16.out_num_a, b16.out_num_match, b16.out_last},
              64'd0);
        check("reset.total", 64'(b16.out_group_total), 64'd0);
        check("reset.out_valid64", 64'(b64.out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Random streaming with random back-pressure.
        do_reset();
        begin
            int n_beats = 1000;
            int sent = 0;
            int got = 0;
            int cyc = 0;
            logic hold_in = 1'b0;
            logic prev_stall = 1'b0;
            logic [63:0] snap_lo = '0;
            logic [15:0] snap_tot = '0;
            while ((sent < n_beats || q.size() != 0) && cyc < 20000) begin
                @(negedge clock);
                cyc++;
                b16.out_ready = 1'($urandom_range(0, 1));
                if (!hold_in) begin
                    if (sent < n_beats && $urandom_range(0, 3) != 0) begin
                        int mode;
                        b16.in_valid = 1'b1;
                        mode = $urandom_range(0, 7);
                        b16.in_bitmask_w = (mode == 0) ? 16'hFFFF : (mode == 1) ? 16'h0000 : 16'($urandom);
                        b16.in_bitmask_a = (mode == 2) ? 16'hFFFF : (mode == 3) ? 16'h0000 : 16'($urandom);
                        b16.in_last = ($urandom_range(0, 3) == 0);
                    end else begin
                        b16.in_valid = 1'b0;
                    end
                end
                #1;
                check("stream.in_ready", 64'(b16.in_ready),
                      64'(!(q.size() == 2 && b16.out_valid && !b16.out_ready)));
                if (prev_stall) begin
                    check("stream.hold_valid", 64'(b16.out_valid), 64'd1);
                    check("stream.hold_data", {b16.out_packed_w, b16.out_packed_a, 1'b0, b16.out_num_w,
                                               b16.out_num_a, b16.out_num_match, b16.out_last},
                          snap_lo);
                    check("stream.hold_total", 64'(b16.out_group_total), 64'(snap_tot));
                end
                prev_stall = b16.out_valid && !b16.out_ready;
                snap_lo = {b16.out_packed_w, b16.out_packed_a, 1'b0, b16.out_num_w,
                           b16.out_num_a, b16.out_num_match, b16.out_last};
                snap_tot = b16.out_group_total;
                if (b16.out_valid && b16.out_ready) begin
                    check("stream.expected_beat", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("stream.packed_w", 64'(b16.out_packed_w), 64'(e.pw));
                        check("stream.packed_a", 64'(b16.out_packed_a), 64'(e.pa));
                        check("stream.counts", {40'd0, 3'd0, b16.out_num_w, 3'd0, b16.out_num_a, 3'd0, b16.out_num_match},
                              {40'd0, 8'(e.nw), 8'(e.na), 8'(e.nm)});
                        check("stream.last", 64'(b16.out_last), 64'(e.last));
                        check("stream.total", 64'(b16.out_group_total), 64'(e.tot));
                        $display("txn rnd%0d w=%h a=%h last=%0d total=%0d", got, e.w, e.a, e.last, e.tot);
                        got++;
                    end
                end
                if (b16.in_valid && b16.in_ready) begin
                    logic [63:0] pw, pa;
                    int nw, na, nm;
                    ref_model(64'(b16.in_bitmask_w), 64'(b16.in_bitmask_a), 16, pw, pa, nw, na, nm);
                    e.w = b16.in_bitmask_w; e.a = b16.in_bitmask_a; e.last = b16.in_last;
                    e.pw = pw[15:0]; e.pa = pa[15:0]; e.nw = nw; e.na = na; e.nm = nm;
                    e.tot = (acc_m + nm > 65535) ? 65535 : acc_m + nm;
                    acc_m = e.last ? 0 : e.tot;
                    q.push_back(e);
                    sent++;
                    hold_in = 1'b0;
                end else begin
                    hold_in = b16.in_valid;
                end
            end
            check("stream.all_delivered", 64'(sent == n_beats && q.size() == 0 && got == n_beats), 64'd1);
            @(negedge clock);
            b16.in_valid = 1'b0;
            b16.out_ready = 1'b1;
        end

        // Reset with two beats in flight and a partial group total of 10.
        do_reset();
        v = '{16'h03FF, 16'h03FF, 1'b0, 16'h03FF, 16'h03FF, 10, 10, 10, 10};
        run_vec(v, "rst_pre");
        @(negedge clock);
        b16.out_ready = 1'b0;
        b16.in_valid = 1'b1; b16.in_bitmask_w = 16'hFFFF; b16.in_bitmask_a = 16'hFFFF; b16.in_last = 1'b0;
        #1 check("rst.accept1", 64'(b16.in_ready), 64'd1);
        @(negedge clock);
        #1 check("rst.accept2", 64'(b16.in_ready), 64'd1);
        @(negedge clock);
        b16.in_valid = 1'b0;
        #1;
        check("rst.full_valid", 64'(b16.out_valid), 64'd1);
        check("rst.full_ready", 64'(b16.in_ready), 64'd0);
        check("rst.stalled_total", 64'(b16.out_group_total), 64'd26);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        acc_m = 0;
        #1;
        check("rst.out_valid", 64'(b16.out_valid), 64'd0);
        check("rst.in_ready", 64'(b16.in_ready), 64'd1);
        check("rst.total", 64'(b16.out_group_total), 64'd0);
        v = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1, 1, 1, 1};
        run_vec(v, "rst_post");

        // Wide instance: all-ones beats with no last saturate an 8-bit total.
        for (int i = 0; i < 5; i++) begin
            int exp_tot;
            exp_tot = (64 * (i + 1) > 255) ? 255 : 64 * (i + 1);
            @(negedge clock);
            b64.out_ready = 1'b1;
            b64.in_valid = 1'b1; b64.in_bitmask_w = '1; b64.in_bitmask_a = '1; b64.in_last = 1'b0;
            @(negedge clock);
            b64.in_valid = 1'b0;
            @(negedge clock);
            check($sformatf("w64[%0d].valid", i), 64'(b64.out_valid), 64'd1);
            check($sformatf("w64[%0d].num_match", i), 64'(b64.out_num_match), 64'd64);
            check($sformatf("w64[%0d].num_w", i), 64'(b64.out_num_w), 64'd64);
            check($sformatf("w64[%0d].packed_w", i), b64.out_packed_w, 64'hFFFF_FFFF_FFFF_FFFF);
            check($sformatf("w64[%0d].total", i), 64'(b64.out_group_total), 64'(exp_tot));
            $display("txn w64_%0d num_match=%0d total=%0d", i, b64.out_num_match, b64.out_group_total);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
